// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the front-panel execution controller:
// FSM state encoding and the fixed roles of the push-buttons.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_STEP  = 2'd2,
    ST_RUN   = 2'd3
  } ctrl_state_t;

  localparam int BTN_STEP = 0;
  localparam int BTN_RUN  = 1;
  localparam int BTN_RST  = 2;

endpackage

// File: rtl/pb_debounce_core.sv
// One push-button channel: 2-flop synchronizer, tick-sampled shift
// register, hysteretic debounced level and a registered rising-edge pulse.
module pb_debounce_core #(
  parameter int SHIFT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  logic                 sync1;
  logic                 sync2;
  logic [SHIFT_LEN-1:0] shift;
  logic                 level_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Take one synchronized sample per shared tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
    end else if (tick) begin
      shift <= {shift[SHIFT_LEN-2:0], sync2};
    end
  end

  // Level only moves once the whole sample window agrees; mixed windows hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
    end else if (&shift) begin
      level <= 1'b1;
    end else if (~|shift) begin
      level <= 1'b0;
    end
  end

  // One-clk pulse on each debounced 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Front-panel execution controller: shared debounce tick, per-button
// debouncers, RESET/HALT/STEP/RUN sequencing and an executed-cycle counter.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int SHIFT_LEN  = 8,
  parameter int N_BTN      = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             running,
  output logic [15:0]      exec_cnt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  ctrl_state_t   state;
  ctrl_state_t   state_next;
  logic [RW-1:0] rst_cnt;
  logic [RW-1:0] rst_cnt_next;

  assign tick    = (tick_cnt == TICK_LAST);
  assign running = (state == ST_RUN);

  // Free-running sample-tick divider shared by every button.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    pb_debounce_core #(
      .SHIFT_LEN(SHIFT_LEN)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // State register and the cycle count spent in RESET.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      rst_cnt <= '0;
    end else begin
      state   <= state_next;
      rst_cnt <= rst_cnt_next;
    end
  end

  // Next-state logic; a reset press overrides everything and restarts the pulse.
  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    if (btn_press[BTN_RST]) begin
      state_next   = ST_RESET;
      rst_cnt_next = '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state_next = ST_HALT;
          end else begin
            rst_cnt_next = rst_cnt + RW'(1);
          end
        end
        ST_HALT: begin
          if (btn_press[BTN_RUN]) begin
            state_next = ST_RUN;
          end else if (btn_press[BTN_STEP]) begin
            state_next = ST_STEP;
          end
        end
        ST_STEP: state_next = ST_HALT;
        ST_RUN: begin
          if (btn_press[BTN_RUN]) begin
            state_next = ST_HALT;
          end
        end
        default: state_next = ST_RESET;
      endcase
    end
  end

  // Registered decodes so cpu_en/cpu_rst are glitch-free flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_en  <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      cpu_en  <= (state_next == ST_STEP) || (state_next == ST_RUN);
      cpu_rst <= (state_next == ST_RESET);
    end
  end

  // Count executed CPU cycles; held at zero while the CPU is being reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_cnt <= '0;
    end else if (state == ST_RESET) begin
      exec_cnt <= '0;
    end else if (cpu_en) begin
      exec_cnt <= exec_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a behavioural reference model.
module tb_cpu_step_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int SHIFT_LEN  = 4;
  localparam int N_BTN      = 4;
  localparam int RST_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn = '0;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             cpu_en;
  logic             cpu_rst;
  logic             running;
  logic [15:0]      exec_cnt;

  cpu_step_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .SHIFT_LEN (SHIFT_LEN),
    .N_BTN     (N_BTN),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .cpu_en   (cpu_en),
    .cpu_rst  (cpu_rst),
    .running  (running),
    .exec_cnt (exec_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: modes, run lengths of agreeing samples, input history
  typedef enum int {M_RST, M_IDLE, M_ONE, M_FREE} mode_t;
  mode_t            m_mode;
  int               m_left;
  int               m_phase;
  logic             m_en;
  logic             m_rstout;
  logic [15:0]      m_exec;
  logic [N_BTN-1:0] m_level;
  logic [N_BTN-1:0] m_level_prev;
  logic [N_BTN-1:0] m_press;
  int               ones_run  [N_BTN];
  int               zeros_run [N_BTN];
  logic [N_BTN-1:0] in_q [$];

  // Observation tallies for directed scenarios
  int en_seen, press0_seen, rst_seen, run_seen, level0_seen;

  task automatic clearTallies();
    en_seen = 0; press0_seen = 0; rst_seen = 0; run_seen = 0; level0_seen = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge given the inputs seen at that edge
  task automatic modelEdge(input logic r, input logic [N_BTN-1:0] b);
    logic [N_BTN-1:0] smp, nlevel, npress;
    mode_t nmode;
    if (r) begin
      m_mode = M_RST; m_left = RST_CYCLES; m_phase = 0;
      m_en = 1'b0; m_rstout = 1'b1; m_exec = '0;
      m_level = '0; m_level_prev = '0; m_press = '0;
      for (int i = 0; i < N_BTN; i++) begin
        ones_run[i] = 0; zeros_run[i] = SHIFT_LEN;
      end
      in_q.delete();
      in_q.push_back('0);
      in_q.push_back('0);
      return;
    end
    m_phase++;
    npress = m_level & ~m_level_prev;
    for (int i = 0; i < N_BTN; i++) begin
      if (ones_run[i] >= SHIFT_LEN)       nlevel[i] = 1'b1;
      else if (zeros_run[i] >= SHIFT_LEN) nlevel[i] = 1'b0;
      else                                nlevel[i] = m_level[i];
    end
    if ((m_phase - 1) % TICK_DIV == TICK_DIV - 1) begin
      smp = in_q[0];
      for (int i = 0; i < N_BTN; i++) begin
        if (smp[i]) begin ones_run[i]++; zeros_run[i] = 0; end
        else        begin zeros_run[i]++; ones_run[i] = 0; end
      end
    end
    void'(in_q.pop_front());
    in_q.push_back(b);
    if (m_mode == M_RST) m_exec = '0;
    else if (m_en)       m_exec = m_exec + 16'd1;
    nmode = m_mode;
    if (m_press[2]) begin
      nmode = M_RST; m_left = RST_CYCLES;
    end else begin
      case (m_mode)
        M_RST: begin
          m_left--;
          if (m_left == 0) nmode = M_IDLE;
        end
        M_IDLE: begin
          if (m_press[1])      nmode = M_FREE;
          else if (m_press[0]) nmode = M_ONE;
        end
        M_ONE:  nmode = M_IDLE;
        M_FREE: if (m_press[1]) nmode = M_IDLE;
        default: nmode = M_RST;
      endcase
    end
    m_en         = (nmode == M_ONE) || (nmode == M_FREE);
    m_rstout     = (nmode == M_RST);
    m_level_prev = m_level;
    m_level      = nlevel;
    m_press      = npress;
    m_mode       = nmode;
  endtask

  task automatic compareAll();
    checkOutput("cpu_en",    {31'd0, cpu_en},  {31'd0, m_en});
    checkOutput("cpu_rst",   {31'd0, cpu_rst}, {31'd0, m_rstout});
    checkOutput("running",   {31'd0, running}, {31'd0, (m_mode == M_FREE)});
    checkOutput("exec_cnt",  {16'd0, exec_cnt}, {16'd0, m_exec});
    checkOutput("btn_level", {28'd0, btn_level}, {28'd0, m_level});
    checkOutput("btn_press", {28'd0, btn_press}, {28'd0, m_press});
  endtask

  // Hold the given inputs for n cycles, sampling #1 after each rising edge
  task automatic applyStimulus(input logic r, input logic [N_BTN-1:0] b, input int n, input bit do_check);
    for (int k = 0; k < n; k++) begin
      rst = r;
      btn = b;
      modelEdge(r, b);
      @(posedge clk);
      #1;
      en_seen     += int'(cpu_en);
      press0_seen += int'(btn_press[0]);
      rst_seen    += int'(cpu_rst);
      run_seen    += int'(running);
      level0_seen += int'(btn_level[0]);
      if (do_check) compareAll();
    end
  endtask

  initial begin
    logic [N_BTN-1:0] rb;
    int guard;

    $display("[TB] start");

    // Reset: three cycles of rst, then the CPU reset pulse runs out
    applyStimulus(1'b1, '0, 2, 1'b1);
    clearTallies();
    applyStimulus(1'b1, '0, 1, 1'b1);
    applyStimulus(1'b0, '0, 9, 1'b1);
    checkOutput("reset_pulse_len", rst_seen, 4);
    checkOutput("reset_no_en", en_seen, 0);
    checkOutput("reset_no_run", run_seen, 0);
    checkOutput("reset_exec", {16'd0, exec_cnt}, 0);

    // Single step from HALT
    clearTallies();
    applyStimulus(1'b0, 4'b0001, 40, 1'b1);
    applyStimulus(1'b0, 4'b0000, 40, 1'b1);
    checkOutput("step_press_pulses", press0_seen, 1);
    checkOutput("step_en_cycles", en_seen, 1);
    checkOutput("step_exec", {16'd0, exec_cnt}, 1);
    checkOutput("step_back_halt", {31'd0, running}, 0);

    // Glitch shorter than the sample window
    clearTallies();
    applyStimulus(1'b0, 4'b0001, 10, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("glitch_level", level0_seen, 0);
    checkOutput("glitch_en", en_seen, 0);

    // Run, step presses ignored in RUN, then halt
    clearTallies();
    applyStimulus(1'b0, 4'b0010, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("run_entered", {31'd0, running}, 1);
    applyStimulus(1'b0, 4'b0001, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("run_after_step_press", {31'd0, running}, 1);
    applyStimulus(1'b0, 4'b0010, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("run_halted", {31'd0, running}, 0);
    checkOutput("run_exec_vs_en", {16'd0, exec_cnt}, 32'(1 + en_seen));
    checkOutput("run_en_matches_running", en_seen, run_seen);

    // Run and step together in HALT: run wins, no step cycle
    clearTallies();
    applyStimulus(1'b0, 4'b0011, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("simul_run", {31'd0, running}, 1);
    checkOutput("simul_no_step", en_seen, run_seen);

    // Reset and run together in RUN: reset wins
    clearTallies();
    applyStimulus(1'b0, 4'b0110, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("simul_rst_pulse_len", rst_seen, 4);
    checkOutput("simul_rst_exec", {16'd0, exec_cnt}, 0);
    checkOutput("simul_rst_halt", {31'd0, running}, 0);

    // Randomized button activity checked against the model
    for (int it = 0; it < 40; it++) begin
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) rb[2] = 1'b0;
      applyStimulus(1'b0, rb, int'($urandom_range(1, 30)), 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 40, 1'b1);

    // Counter wrap in RUN
    applyStimulus(1'b1, '0, 2, 1'b1);
    applyStimulus(1'b0, '0, 8, 1'b1);
    applyStimulus(1'b0, 4'b0010, 30, 1'b1);
    applyStimulus(1'b0, 4'b0000, 30, 1'b1);
    checkOutput("wrap_running", {31'd0, running}, 1);
    guard = 0;
    while (m_exec != 16'hFFFE && guard < 70000) begin
      applyStimulus(1'b0, 4'b0000, 1, 1'b0);
      guard++;
    end
    checkOutput("wrap_reached", {16'd0, m_exec}, 32'h0000FFFE);
    compareAll();
    checkOutput("wrap_fffe", {16'd0, exec_cnt}, 32'h0000FFFE);
    applyStimulus(1'b0, 4'b0000, 1, 1'b1);
    checkOutput("wrap_ffff", {16'd0, exec_cnt}, 32'h0000FFFF);
    applyStimulus(1'b0, 4'b0000, 1, 1'b1);
    checkOutput("wrap_0000", {16'd0, exec_cnt}, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
